// File: rtl/action_applier.sv
// Applies queued per-packet lookup actions to an AXI4-Stream packet flow.
// Each packet is either forwarded with port/vport stamped into tuser, or dropped.
module action_applier #(
  parameter int C_DATA_WIDTH        = 256,
  parameter int C_TUSER_WIDTH       = 128,
  parameter int C_OUT_PORT_WIDTH    = 8,
  parameter int C_MATCH_ADDR_WIDTH  = 10,
  parameter int C_ACTION_FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          action_valid,
  input  logic                          action_match,
  input  logic [C_OUT_PORT_WIDTH-1:0]   action_port,
  input  logic [C_OUT_PORT_WIDTH-1:0]   action_vport,
  input  logic [1:0]                    action_type,
  input  logic [C_MATCH_ADDR_WIDTH-1:0] action_match_addr,
  input  logic [C_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0]     s_axis_tkeep,
  input  logic [C_TUSER_WIDTH-1:0]      s_axis_tuser,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [C_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0]     m_axis_tkeep,
  output logic [C_TUSER_WIDTH-1:0]      m_axis_tuser,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [C_MATCH_ADDR_WIDTH-1:0] last_match_addr,
  output logic [31:0]                   fwd_count,
  output logic [31:0]                   drop_count,
  output logic                          action_overflow
);

  localparam int AW = $clog2(C_ACTION_FIFO_DEPTH);

  typedef struct packed {
    logic                          match;
    logic [C_OUT_PORT_WIDTH-1:0]   port;
    logic [C_OUT_PORT_WIDTH-1:0]   vport;
    logic [1:0]                    atype;
    logic [C_MATCH_ADDR_WIDTH-1:0] addr;
  } act_t;

  typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, DROP = 2'd2} state_t;

  function automatic logic [C_TUSER_WIDTH-1:0] stamp_tuser(
    input logic [C_TUSER_WIDTH-1:0]    u,
    input logic [C_OUT_PORT_WIDTH-1:0] port,
    input logic [C_OUT_PORT_WIDTH-1:0] vport
  );
    logic [C_TUSER_WIDTH-1:0] r;
    r = u;
    r[24 +: C_OUT_PORT_WIDTH] = port;
    r[32 +: C_OUT_PORT_WIDTH] = vport;
    return r;
  endfunction

  act_t                          fifo_mem [C_ACTION_FIFO_DEPTH];
  logic [AW:0]                   wr_ptr, rd_ptr;
  logic                          fifo_empty, fifo_full;
  logic                          push, dispatch;
  act_t                          head, act_in;
  logic                          head_drop;
  state_t                        state_q, state_d;
  logic                          accept, fwd_accept;
  logic [C_OUT_PORT_WIDTH-1:0]   act_port, act_vport;
  logic [C_MATCH_ADDR_WIDTH-1:0] act_addr;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dispatch   = (state_q == IDLE) && !fifo_empty && s_axis_tvalid;
  // A full queue still accepts a write when the head is popped in the same cycle.
  assign push       = action_valid && (!fifo_full || dispatch);
  assign head       = fifo_mem[rd_ptr[AW-1:0]];
  assign head_drop  = !head.match || (head.port == '0) || (head.atype == 2'd1);
  assign act_in     = '{match: action_match, port: action_port, vport: action_vport,
                        atype: action_type, addr: action_match_addr};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      action_overflow <= 1'b0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + 1'b1;
      if (dispatch) rd_ptr <= rd_ptr + 1'b1;
      if (action_valid && fifo_full && !dispatch) action_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= act_in;
  end

  always_ff @(posedge clk) begin
    if (dispatch) begin
      act_port  <= head.port;
      act_vport <= head.vport;
      act_addr  <= head.addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dispatch) state_d = head_drop ? DROP : FWD;
      FWD,
      DROP:    if (accept && s_axis_tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b0;
    case (state_q)
      FWD:     s_axis_tready = !m_axis_tvalid || m_axis_tready;
      DROP:    s_axis_tready = 1'b1;
      default: s_axis_tready = 1'b0;
    endcase
  end

  assign accept     = s_axis_tvalid && s_axis_tready;
  assign fwd_accept = accept && (state_q == FWD);

  // Stage p1: single output register slice, drains regardless of state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (fwd_accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tkeep  <= s_axis_tkeep;
      m_axis_tuser  <= stamp_tuser(s_axis_tuser, act_port, act_vport);
      m_axis_tlast  <= s_axis_tlast;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_count       <= '0;
      drop_count      <= '0;
      last_match_addr <= '0;
    end else if (accept && s_axis_tlast) begin
      if (state_q == FWD) begin
        fwd_count       <= fwd_count + 32'd1;
        last_match_addr <= act_addr;
      end else if (state_q == DROP) begin
        drop_count      <= drop_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_action_applier.sv
// Directed self-checking bench for action_applier.
module tb_action_applier;

  localparam int DW = 256, TW = 128, PW = 8, MW = 10, KW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          action_valid, action_match;
  logic [PW-1:0] action_port, action_vport;
  logic [1:0]    action_type;
  logic [MW-1:0] action_match_addr;
  logic [DW-1:0] s_axis_tdata, m_axis_tdata;
  logic [KW-1:0] s_axis_tkeep, m_axis_tkeep;
  logic [TW-1:0] s_axis_tuser, m_axis_tuser;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [MW-1:0] last_match_addr;
  logic [31:0]   fwd_count, drop_count;
  logic          action_overflow;

  action_applier dut (
    .clk(clk), .reset(reset),
    .action_valid(action_valid), .action_match(action_match),
    .action_port(action_port), .action_vport(action_vport),
    .action_type(action_type), .action_match_addr(action_match_addr),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .last_match_addr(last_match_addr), .fwd_count(fwd_count),
    .drop_count(drop_count), .action_overflow(action_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [TW-1:0] u;
    logic          l;
  } beat_t;

  beat_t         out_q[$];
  int            vec = 0, err = 0;
  int            cyc = 0, mv_cycles = 0, unstable = 0, body_waits = 0;
  logic [7:0]    rdy_pat = 8'hFF;
  logic          acc, prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  int            exp_fwd = 0, exp_drop = 0;

  function automatic logic [DW-1:0] mk_data(input logic [7:0] id, input logic [7:0] b);
    return {8{id, b, 16'hC0DE}};
  endfunction

  function automatic logic [TW-1:0] mk_user(input logic [7:0] id, input logic [7:0] b);
    return {72'hFE_EDFA_CE0B_ADF0_0D77, 16'h1234, 8'hFF, 8'hFF, 8'h5A, id, b};
  endfunction

  function automatic logic [TW-1:0] exp_user(input logic [7:0] id, input logic [7:0] b,
                                             input logic [7:0] p, input logic [7:0] v);
    logic [TW-1:0] u;
    u = mk_user(id, b);
    u[31:24] = p;
    u[39:32] = v;
    return u;
  endfunction

  // One clock cycle: called at a negedge with inputs already driven.
  task automatic step();
    m_axis_tready = rdy_pat[cyc % 8];
    cyc++;
    #1;
    acc = s_axis_tvalid && s_axis_tready;
    if (m_axis_tvalid) mv_cycles++;
    if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_data)) unstable++;
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    if (m_axis_tvalid && m_axis_tready)
      out_q.push_back('{d: m_axis_tdata, k: m_axis_tkeep, u: m_axis_tuser, l: m_axis_tlast});
    @(negedge clk);
  endtask

  task automatic push_action(input logic m, input logic [7:0] p, input logic [7:0] v,
                             input logic [1:0] t, input logic [MW-1:0] a);
    action_valid = 1'b1; action_match = m; action_port = p; action_vport = v;
    action_type = t; action_match_addr = a;
    step();
    action_valid = 1'b0;
  endtask

  task automatic send_beats(input logic [7:0] id, input int nsend, input int total);
    int waits;
    for (int b = 0; b < nsend; b++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = mk_data(id, 8'(b));
      s_axis_tuser  = mk_user(id, 8'(b));
      s_axis_tlast  = (b == total - 1);
      s_axis_tkeep  = (b == total - 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      acc = 1'b0;
      waits = 0;
      while (!acc && waits < 64) begin
        step();
        waits++;
      end
      if (!acc) begin
        vec++; err++;
        $display("FAIL beat_timeout pkt %0d beat %0d not accepted within 64 cycles", id, b);
      end
      if (b > 0 && waits > 1) body_waits++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    vec++; if (m_axis_tvalid !== 1'b0) begin err++; $display("FAIL rst_m_tvalid got %b want 0", m_axis_tvalid); end
    vec++; if (s_axis_tready !== 1'b0) begin err++; $display("FAIL rst_s_tready got %b want 0", s_axis_tready); end
    vec++; if (action_overflow !== 1'b0) begin err++; $display("FAIL rst_overflow got %b want 0", action_overflow); end
    vec++; if (fwd_count !== 32'd0 || drop_count !== 32'd0)
      begin err++; $display("FAIL rst_counts got %0d/%0d want 0/0", fwd_count, drop_count); end
    vec++; if (last_match_addr !== '0) begin err++; $display("FAIL rst_last_addr got %0d want 0", last_match_addr); end
    vec++; if (m_axis_tdata !== '0 || m_axis_tuser !== '0 || m_axis_tkeep !== '0 || m_axis_tlast !== 1'b0)
      begin err++; $display("FAIL rst_m_payload got nonzero m_axis fields want 0"); end
  endtask

  task automatic test_forward();
    out_q.delete();
    push_action(1'b1, 8'h20, 8'h04, 2'd0, 10'd3);
    send_beats(8'd1, 3, 3);
    drain(4);
    exp_fwd++;
    vec++; if (out_q.size() != 3) begin err++; $display("FAIL fwd_beats got %0d want 3", out_q.size()); end
    for (int i = 0; i < out_q.size() && i < 3; i++) begin
      vec++; if (out_q[i].u !== exp_user(8'd1, 8'(i), 8'h20, 8'h04))
        begin err++; $display("FAIL fwd_tuser beat %0d got %h want %h", i, out_q[i].u, exp_user(8'd1, 8'(i), 8'h20, 8'h04)); end
      vec++; if (out_q[i].d !== mk_data(8'd1, 8'(i)) || out_q[i].l !== (i == 2) ||
                 out_q[i].k !== ((i == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF))
        begin err++; $display("FAIL fwd_payload beat %0d got d=%h l=%b k=%h", i, out_q[i].d[31:0], out_q[i].l, out_q[i].k); end
    end
    vec++; if (fwd_count !== 32'(exp_fwd)) begin err++; $display("FAIL fwd_count got %0d want %0d", fwd_count, exp_fwd); end
    vec++; if (last_match_addr !== 10'd3) begin err++; $display("FAIL fwd_last_addr got %0d want 3", last_match_addr); end
  endtask

  task automatic test_drop();
    out_q.delete();
    mv_cycles = 0; body_waits = 0;
    push_action(1'b0, 8'h01, 8'h01, 2'd0, 10'd10);
    push_action(1'b1, 8'h00, 8'h01, 2'd0, 10'd11);
    push_action(1'b1, 8'h02, 8'h01, 2'd1, 10'd12);
    for (int p = 0; p < 3; p++) send_beats(8'(20 + p), 3, 3);
    drain(3);
    exp_drop += 3;
    vec++; if (mv_cycles != 0) begin err++; $display("FAIL drop_m_tvalid got %0d valid cycles want 0", mv_cycles); end
    vec++; if (drop_count !== 32'(exp_drop)) begin err++; $display("FAIL drop_count got %0d want %0d", drop_count, exp_drop); end
    vec++; if (body_waits != 0) begin err++; $display("FAIL drop_tready got %0d stalled body beats want 0", body_waits); end
    vec++; if (fwd_count !== 32'(exp_fwd)) begin err++; $display("FAIL drop_fwd_count got %0d want %0d", fwd_count, exp_fwd); end
  endtask

  task automatic test_backpressure();
    out_q.delete();
    unstable = 0;
    rdy_pat = 8'b1001_1001;
    push_action(1'b1, 8'h08, 8'h10, 2'd0, 10'd5);
    send_beats(8'd30, 4, 4);
    drain(12);
    rdy_pat = 8'hFF;
    drain(2);
    exp_fwd++;
    vec++; if (out_q.size() != 4) begin err++; $display("FAIL bp_beats got %0d want 4", out_q.size()); end
    for (int i = 0; i < out_q.size() && i < 4; i++) begin
      vec++; if (out_q[i].d !== mk_data(8'd30, 8'(i)) || out_q[i].u !== exp_user(8'd30, 8'(i), 8'h08, 8'h10))
        begin err++; $display("FAIL bp_order beat %0d got d=%h want d=%h", i, out_q[i].d[31:0], mk_data(8'd30, 8'(i)) & 256'hFFFF_FFFF); end
    end
    vec++; if (unstable != 0) begin err++; $display("FAIL bp_stable got %0d unstable stalls want 0", unstable); end
    vec++; if (fwd_count !== 32'(exp_fwd)) begin err++; $display("FAIL bp_fwd_count got %0d want %0d", fwd_count, exp_fwd); end
  endtask

  task automatic test_overflow();
    logic any_acc;
    out_q.delete();
    for (int i = 1; i <= 8; i++) begin
      push_action(1'b1, 8'(i), 8'(i), 2'd0, 10'(i));
      vec++; if (action_overflow !== 1'b0) begin err++; $display("FAIL ovf_early push %0d got 1 want 0", i); end
    end
    push_action(1'b1, 8'd9, 8'd9, 2'd0, 10'd9);
    vec++; if (action_overflow !== 1'b1) begin err++; $display("FAIL ovf_set got %b want 1", action_overflow); end
    for (int p = 1; p <= 8; p++) send_beats(8'(40 + p), 1, 1);
    drain(3);
    exp_fwd += 8;
    vec++; if (out_q.size() != 8) begin err++; $display("FAIL ovf_beats got %0d want 8", out_q.size()); end
    for (int i = 0; i < out_q.size() && i < 8; i++) begin
      vec++; if (out_q[i].u !== exp_user(8'(41 + i), 8'd0, 8'(i + 1), 8'(i + 1)))
        begin err++; $display("FAIL ovf_order pkt %0d got port %h want %h", i + 1, out_q[i].u[31:24], 8'(i + 1)); end
    end
    vec++; if (last_match_addr !== 10'd8) begin err++; $display("FAIL ovf_last_addr got %0d want 8", last_match_addr); end
    any_acc = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1;
    s_axis_tdata = mk_data(8'd49, 8'd0); s_axis_tuser = mk_user(8'd49, 8'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      any_acc |= acc;
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    vec++; if (any_acc !== 1'b0) begin err++; $display("FAIL ovf_ninth_wait got accepted want held in IDLE"); end
    vec++; if (fwd_count !== 32'(exp_fwd) || action_overflow !== 1'b1)
      begin err++; $display("FAIL ovf_final got fwd=%0d ovf=%b want %0d/1", fwd_count, action_overflow, exp_fwd); end
  endtask

  task automatic test_back_to_back();
    out_q.delete();
    push_action(1'b1, 8'h11, 8'h01, 2'd0, 10'd101);
    push_action(1'b1, 8'h22, 8'h02, 2'd1, 10'd102);
    push_action(1'b1, 8'h33, 8'h03, 2'd2, 10'd103);
    push_action(1'b0, 8'h44, 8'h04, 2'd0, 10'd104);
    for (int p = 0; p < 4; p++) send_beats(8'(60 + p), 1, 1);
    drain(3);
    exp_fwd += 2; exp_drop += 2;
    vec++; if (fwd_count !== 32'(exp_fwd) || drop_count !== 32'(exp_drop))
      begin err++; $display("FAIL b2b_counts got %0d/%0d want %0d/%0d", fwd_count, drop_count, exp_fwd, exp_drop); end
    vec++; if (out_q.size() != 2) begin err++; $display("FAIL b2b_beats got %0d want 2", out_q.size()); end
    if (out_q.size() == 2) begin
      vec++; if (out_q[0].u !== exp_user(8'd60, 8'd0, 8'h11, 8'h01))
        begin err++; $display("FAIL b2b_first got %h want %h", out_q[0].u, exp_user(8'd60, 8'd0, 8'h11, 8'h01)); end
      vec++; if (out_q[1].u !== exp_user(8'd62, 8'd0, 8'h33, 8'h03))
        begin err++; $display("FAIL b2b_second got %h want %h", out_q[1].u, exp_user(8'd62, 8'd0, 8'h33, 8'h03)); end
    end
    vec++; if (last_match_addr !== 10'd103) begin err++; $display("FAIL b2b_last_addr got %0d want 103", last_match_addr); end
  endtask

  task automatic test_reset_mid_packet();
    push_action(1'b1, 8'h40, 8'h02, 2'd0, 10'd7);
    send_beats(8'd70, 2, 5);
    #2 reset = 1'b1;
    #1;
    vec++; if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0)
      begin err++; $display("FAIL mid_rst_handshake got v=%b r=%b want 0/0", m_axis_tvalid, s_axis_tready); end
    vec++; if (fwd_count !== 32'd0 || drop_count !== 32'd0 || action_overflow !== 1'b0 || last_match_addr !== '0)
      begin err++; $display("FAIL mid_rst_status got fwd=%0d drop=%0d ovf=%b addr=%0d want 0", fwd_count, drop_count, action_overflow, last_match_addr); end
    vec++; if (m_axis_tdata !== '0 || m_axis_tlast !== 1'b0)
      begin err++; $display("FAIL mid_rst_payload got tlast=%b want 0 with zero data", m_axis_tlast); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
    out_q.delete();
    push_action(1'b1, 8'h80, 8'h01, 2'd0, 10'd9);
    send_beats(8'd71, 2, 2);
    drain(3);
    vec++; if (out_q.size() != 2) begin err++; $display("FAIL post_rst_beats got %0d want 2", out_q.size()); end
    if (out_q.size() == 2) begin
      vec++; if (out_q[1].u !== exp_user(8'd71, 8'd1, 8'h80, 8'h01) || out_q[1].l !== 1'b1)
        begin err++; $display("FAIL post_rst_tuser got %h want %h", out_q[1].u, exp_user(8'd71, 8'd1, 8'h80, 8'h01)); end
    end
    vec++; if (fwd_count !== 32'd1 || last_match_addr !== 10'd9)
      begin err++; $display("FAIL post_rst_count got fwd=%0d addr=%0d want 1/9", fwd_count, last_match_addr); end
  endtask

  initial begin
    reset = 1'b1;
    action_valid = 1'b0; action_match = 1'b0; action_port = '0; action_vport = '0;
    action_type = '0; action_match_addr = '0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    step();
    test_reset();
    test_forward();
    test_drop();
    test_backpressure();
    test_overflow();
    test_back_to_back();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
